conv_ctrl_seq: RTL and testbench



---
 rtl/conv_ctrl_seq.sv | 207 ++++++++++++++++++++
 tb/tb_conv_ctrl_seq.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ctrl_seq.sv
// conv_ctrl_seq: APB-programmed layer sequencer stepping LOAD_F/LOAD_B/COMPUTE/SEND per output-channel group.
// Optional feature macro CONV_CTRL_IRQ_EN adds the IRQ_EN register and the level interrupt.
module conv_ctrl_seq #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned CH_W    = 12,
   parameter int unsigned FLEN_W  = 16,
   parameter int unsigned OCH_PAR = 8
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic [15:0]       PADDR,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic [2:0]        command,
   output logic [CH_W-1:0]   grp_idx,
   output logic [CH_W-1:0]   num_inch,
   output logic [CH_W-1:0]   num_outch,
   output logic [FLEN_W-1:0] flen,
   output logic              conv_start,
   output logic              conv_done,
   input  logic              f_writedone,
   input  logic              b_writedone,
   input  logic              rdy_to_send,
   input  logic              send_done,
   output logic              irq
);
   localparam logic [15:0] A_CTRL      = 16'h0000;
   localparam logic [15:0] A_STATUS    = 16'h0004;
   localparam logic [15:0] A_NUM_INCH  = 16'h0008;
   localparam logic [15:0] A_NUM_OUTCH = 16'h000C;
   localparam logic [15:0] A_FLEN      = 16'h0010;
   localparam logic [15:0] A_CYCLES    = 16'h0014;
   localparam logic [15:0] A_IRQ_EN    = 16'h0018;
   localparam logic [CH_W-1:0] OCH_PAR_W = CH_W'(OCH_PAR);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_F  = 3'd1,
      ST_LOAD_B  = 3'd2,
      ST_COMPUTE = 3'd3,
      ST_SEND    = 3'd4
   } state_t;

   state_t              state, state_nxt;
   logic [CH_W-1:0]     grp_nxt;
   logic [CH_W-1:0]     last_grp;
   logic                start_nxt, done_nxt;
   logic                sts_done, sts_err, sts_aborted;
   logic [DATA_W-1:0]   cycles;
   logic                busy;
   logic                addr_ok, cfg_sel;
   logic                wr_ok, ctrl_wr, sts_wr;
   logic                start_req, abort_acc, cfg_ok, start_acc, start_err;
   logic                unused_pwdata;

   assign busy    = (state != ST_IDLE);
   assign command = state;
   assign PREADY  = 1'b1;

   // Address decode; config registers are the ones locked while a layer runs
   always_comb begin
      addr_ok = 1'b0;
      cfg_sel = 1'b0;
      case (PADDR)
         A_CTRL, A_STATUS, A_CYCLES, A_IRQ_EN: addr_ok = 1'b1;
         A_NUM_INCH, A_NUM_OUTCH, A_FLEN: begin
            addr_ok = 1'b1;
            cfg_sel = 1'b1;
         end
         default: ;
      endcase
   end

   assign PSLVERR   = PSEL & PENABLE & (~addr_ok | (PWRITE & cfg_sel & busy));
   assign wr_ok     = PSEL & PENABLE & PWRITE & ~PSLVERR;
   assign ctrl_wr   = wr_ok & (PADDR == A_CTRL);
   assign sts_wr    = wr_ok & (PADDR == A_STATUS);
   assign start_req = ctrl_wr & PWDATA[0] & ~PWDATA[1];
   assign abort_acc = ctrl_wr & PWDATA[1] & busy;
   assign cfg_ok    = (num_inch != '0) & (num_outch != '0) & (flen != '0);
   assign start_acc = start_req & ~busy & cfg_ok;
   assign start_err = start_req & ~busy & ~cfg_ok;

   assign unused_pwdata = ^PWDATA;

   // Next-state: abort overrides any phase pulse sampled in the same cycle
   always_comb begin
      state_nxt = state;
      grp_nxt   = grp_idx;
      start_nxt = 1'b0;
      done_nxt  = 1'b0;
      if (abort_acc) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_acc) begin
                  state_nxt = ST_LOAD_F;
                  grp_nxt   = '0;
                  start_nxt = 1'b1;
               end
            end
            ST_LOAD_F:  if (f_writedone) state_nxt = ST_LOAD_B;
            ST_LOAD_B:  if (b_writedone) state_nxt = ST_COMPUTE;
            ST_COMPUTE: if (rdy_to_send) state_nxt = ST_SEND;
            ST_SEND: begin
               if (send_done) begin
                  if (grp_idx == last_grp) begin
                     state_nxt = ST_IDLE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = ST_LOAD_F;
                     grp_nxt   = grp_idx + CH_W'(1);
                  end
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state      <= ST_IDLE;
         grp_idx    <= '0;
         last_grp   <= '0;
         conv_start <= 1'b0;
         conv_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         grp_idx    <= grp_nxt;
         conv_start <= start_nxt;
         conv_done  <= done_nxt;
         // ceil(n/P)-1 == floor((n-1)/P) for n >= 1, which start_acc guarantees
         if (start_acc) last_grp <= (num_outch - CH_W'(1)) / OCH_PAR_W;
      end
   end

   // Config, sticky status (sets win over same-cycle W1C) and busy-cycle counter
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         num_inch    <= '0;
         num_outch   <= '0;
         flen        <= '0;
         sts_done    <= 1'b0;
         sts_err     <= 1'b0;
         sts_aborted <= 1'b0;
         cycles      <= '0;
      end else begin
         if (wr_ok && PADDR == A_NUM_INCH)  num_inch  <= PWDATA[CH_W-1:0];
         if (wr_ok && PADDR == A_NUM_OUTCH) num_outch <= PWDATA[CH_W-1:0];
         if (wr_ok && PADDR == A_FLEN)      flen      <= PWDATA[FLEN_W-1:0];
         if (sts_wr) begin
            if (PWDATA[1]) sts_done    <= 1'b0;
            if (PWDATA[2]) sts_err     <= 1'b0;
            if (PWDATA[3]) sts_aborted <= 1'b0;
         end
         if (start_acc) begin
            sts_done    <= 1'b0;
            sts_err     <= 1'b0;
            sts_aborted <= 1'b0;
         end
         if (start_err) sts_err     <= 1'b1;
         if (done_nxt)  sts_done    <= 1'b1;
         if (abort_acc) sts_aborted <= 1'b1;
         if (start_acc)                  cycles <= '0;
         else if (busy && cycles != '1)  cycles <= cycles + DATA_W'(1);
      end
   end

`ifdef CONV_CTRL_IRQ_EN
   logic irq_en;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN)                          irq_en <= 1'b0;
      else if (wr_ok && PADDR == A_IRQ_EN)  irq_en <= PWDATA[0];
   end

   assign irq = irq_en & (sts_done | sts_err | sts_aborted);
`else
   assign irq = 1'b0;
`endif

   // Zero-wait read mux, driven only during read transfers
   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE) begin
         case (PADDR)
            A_STATUS:    PRDATA = DATA_W'({command, sts_aborted, sts_err, sts_done, busy});
            A_NUM_INCH:  PRDATA = DATA_W'(num_inch);
            A_NUM_OUTCH: PRDATA = DATA_W'(num_outch);
            A_FLEN:      PRDATA = DATA_W'(flen);
            A_CYCLES:    PRDATA = cycles;
`ifdef CONV_CTRL_IRQ_EN
            A_IRQ_EN:    PRDATA = DATA_W'(irq_en);
`endif
            default:     PRDATA = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_ctrl_seq.sv
// tb_conv_ctrl_seq: register table, directed layer jobs and randomized jobs for conv_ctrl_seq.
// Busy-cycle and group expectations come from interval lengths and ceil(OUTCH/8) arithmetic.
module tb_conv_ctrl_seq;
   logic        CLK, RESETN;
   logic [15:0] PADDR;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PWDATA, PRDATA;
   logic        PREADY, PSLVERR;
   logic [2:0]  command;
   logic [11:0] grp_idx, num_inch, num_outch;
   logic [15:0] flen;
   logic        conv_start, conv_done;
   logic        f_writedone, b_writedone, rdy_to_send, send_done;
   logic        irq;

   conv_ctrl_seq dut (
      .CLK(CLK), .RESETN(RESETN), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .command(command), .grp_idx(grp_idx), .num_inch(num_inch), .num_outch(num_outch),
      .flen(flen), .conv_start(conv_start), .conv_done(conv_done),
      .f_writedone(f_writedone), .b_writedone(b_writedone), .rdy_to_send(rdy_to_send),
      .send_done(send_done), .irq(irq)
   );

`ifdef CONV_CTRL_IRQ_EN
   localparam bit IRQ_BUILD = 1'b1;
`else
   localparam bit IRQ_BUILD = 1'b0;
`endif

   typedef struct {
      logic [15:0] addr;
      bit          wr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          err;
   } vec_t;

   int n_tests = 0, n_fail = 0;
   int n_start = 0, n_done = 0;
   int tb_cyc = 0;
   bit m_done = 0, m_err = 0, m_abt = 0, m_irq_en = 0;
   vec_t vecs[$];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) tb_cyc++;
   always @(negedge CLK) begin
      if (conv_start === 1'b1) n_start++;
      if (conv_done === 1'b1)  n_done++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_irq();
      return IRQ_BUILD & m_irq_en & (m_done | m_err | m_abt);
   endfunction

   // Tasks start and end 1ns after a rising edge
   task automatic apb_write(input logic [15:0] a, input logic [31:0] d, output logic e);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
      @(posedge CLK); #1;
      PENABLE = 1'b1;
      #1 e = PSLVERR;
      @(posedge CLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic e);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
      @(posedge CLK); #1;
      PENABLE = 1'b1;
      #1 d = PRDATA; e = PSLVERR;
      @(posedge CLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic set_pulse(input int w, input logic v);
      case (w)
         1: f_writedone = v;
         2: b_writedone = v;
         3: rdy_to_send = v;
         4: send_done   = v;
         default: ;
      endcase
   endtask

   task automatic check_status(input logic busy_e, input logic [2:0] cmd_e);
      logic [31:0] rd;
      logic e;
      apb_read(16'h04, rd, e);
      check("status", rd, {25'b0, cmd_e, m_abt, m_err, m_done, busy_e});
   endtask

   // Expect phase p of group g, wait d cycles with stray non-matching pulses, then complete it
   task automatic run_phase(input int p, input int g, input int d);
      int w;
      check($sformatf("cmd_g%0d_p%0d", g, p), command, p);
      check($sformatf("grp_g%0d_p%0d", g, p), grp_idx, g);
      for (int i = 0; i < d; i++) begin
         w = 0;
         if ($urandom_range(0, 2) == 0) begin
            w = (p + int'($urandom_range(0, 2))) % 4 + 1;
            set_pulse(w, 1'b1);
         end
         @(posedge CLK); #1;
         if (w != 0) set_pulse(w, 1'b0);
      end
      set_pulse(p, 1'b1);
      @(posedge CLK); #1;
      set_pulse(p, 1'b0);
   endtask

   // Start+abort CTRL write whose access cycle coincides with the phase-p completion pulse
   task automatic abort_phase(input int p, input int g);
      check($sformatf("abt_cmd_g%0d", g), command, p);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 16'h00; PWDATA = 32'h3;
      @(posedge CLK); #1;
      PENABLE = 1'b1;
      set_pulse(p, 1'b1);
      @(posedge CLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      set_pulse(p, 1'b0);
   endtask

   task automatic start_job(input int inch, input int outch, input int fl);
      logic e;
      apb_write(16'h08, 32'(inch), e);
      apb_write(16'h0C, 32'(outch), e);
      apb_write(16'h10, 32'(fl), e);
      apb_write(16'h00, 32'h1, e);
      check("start_err", e, 0);
      check("conv_start", conv_start, 1);
      check("start_cmd", command, 1);
      m_done = 0; m_err = 0; m_abt = 0;
   endtask

   task automatic run_job(input int inch, input int outch, input int fl, input int dly,
                          input bit pokes, input int abort_g, input int abort_p);
      logic [31:0] rd;
      logic e;
      int ngrp, c0, c1, s0, d0;
      bit aborted;
      s0 = n_start; d0 = n_done;
      start_job(inch, outch, fl);
      c0 = tb_cyc;
      check("num_outch", num_outch, outch);
      check("flen_port", flen, fl);
      ngrp = outch / 8 + ((outch % 8 != 0) ? 1 : 0);
      aborted = 0;
      for (int g = 0; g < ngrp && !aborted; g++) begin
         for (int p = 1; p <= 4 && !aborted; p++) begin
            if (pokes && g == 0 && p == 1) begin
               apb_write(16'h10, 32'h99, e);
               check("flen_busy_err", e, 1);
               apb_read(16'h10, rd, e);
               check("flen_hold", rd, fl);
               check("flen_rd_err", e, 0);
               apb_write(16'h00, 32'h1, e);
               check("start_busy_err", e, 0);
               check("start_busy_pulse", conv_start, 0);
               b_writedone = 1'b1;
               @(posedge CLK); #1;
               b_writedone = 1'b0;
               check("stray_bwd_cmd", command, 1);
               check_status(1, 1);
            end
            if (g == abort_g && p == abort_p) begin
               abort_phase(p, g);
               aborted = 1;
            end else begin
               run_phase(p, g, (dly < 0) ? int'($urandom_range(0, 3)) : dly);
            end
         end
      end
      c1 = tb_cyc;
      check("end_cmd", command, 0);
      check("conv_done", conv_done, aborted ? 0 : 1);
      check("no_restart", conv_start, 0);
      if (aborted) m_abt = 1; else m_done = 1;
      repeat (2) @(posedge CLK);
      #1;
      check_status(0, 0);
      apb_read(16'h14, rd, e);
      check("cycles", rd, 32'(c1 - c0));
      check("start_pulses", n_start - s0, 1);
      check("done_pulses", n_done - d0, aborted ? 0 : 1);
      check("irq_end", irq, exp_irq());
   endtask

   initial begin
      logic [31:0] rd;
      logic e;
      int inch, outch, fl, ngrp, ag, ap, c0;

      RESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      f_writedone = 1'b0; b_writedone = 1'b0; rdy_to_send = 1'b0; send_done = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RESETN = 1'b1;
      @(posedge CLK); #1;
      check("rst_cmd", command, 0);
      check("rst_grp", grp_idx, 0);
      check("rst_start", conv_start, 0);
      check("rst_done", conv_done, 0);
      check("rst_irq", irq, 0);
      check("rst_prdata", PRDATA, 0);
      check("rst_pslverr", PSLVERR, 0);
      check("rst_pready", PREADY, 1);
      check("rst_inch", num_inch, 0);

      // Register-map vectors while idle
      vecs.push_back('{16'h04, 0, 32'h0,        32'h0,   0});
      vecs.push_back('{16'h14, 0, 32'h0,        32'h0,   0});
      vecs.push_back('{16'h08, 1, 32'hFFFFF123, 32'h0,   0});
      vecs.push_back('{16'h08, 0, 32'h0,        32'h123, 0});
      vecs.push_back('{16'h0C, 1, 32'h10,       32'h0,   0});
      vecs.push_back('{16'h0C, 0, 32'h0,        32'h10,  0});
      vecs.push_back('{16'h10, 1, 32'hABCD0040, 32'h0,   0});
      vecs.push_back('{16'h10, 0, 32'h0,        32'h40,  0});
      vecs.push_back('{16'h14, 1, 32'h55,       32'h0,   0});
      vecs.push_back('{16'h14, 0, 32'h0,        32'h0,   0});
      vecs.push_back('{16'h00, 1, 32'h3,        32'h0,   0});
      vecs.push_back('{16'h00, 1, 32'h2,        32'h0,   0});
      vecs.push_back('{16'h04, 0, 32'h0,        32'h0,   0});
      vecs.push_back('{16'h00, 0, 32'h0,        32'h0,   0});
      vecs.push_back('{16'h20, 0, 32'h0,        32'h0,   1});
      vecs.push_back('{16'h02, 0, 32'h0,        32'h0,   1});
      vecs.push_back('{16'h1C, 1, 32'h1,        32'h0,   1});
      vecs.push_back('{16'h18, 1, 32'h1,        32'h0,   0});
      vecs.push_back('{16'h18, 0, 32'h0,        32'(IRQ_BUILD), 0});
      vecs.push_back('{16'h18, 1, 32'h0,        32'h0,   0});
      vecs.push_back('{16'h18, 0, 32'h0,        32'h0,   0});
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].wr) begin
            apb_write(vecs[i].addr, vecs[i].wdata, e);
         end else begin
            apb_read(vecs[i].addr, rd, e);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
         end
         check($sformatf("vec%0d_err", i), e, vecs[i].err);
      end
      check("vec_inch", num_inch, 12'h123);
      check("vec_flen", flen, 16'h40);
      check("vec_cmd", command, 0);
      check("vec_no_start", n_start, 0);
      check("vec_prdata_nosel", PRDATA, 0);

      // Two groups, every phase answered two cycles late
      run_job(3, 16, 64, 2, 0, -1, -1);
      // OUTCH=9 still needs two groups
      run_job(1, 9, 5, -1, 0, -1, -1);

      // Zero NUM_OUTCH at start flags err and never starts
      apb_write(16'h0C, 32'h0, e);
      c0 = n_start;
      apb_write(16'h00, 32'h1, e);
      check("zero_start_pulse", conv_start, 0);
      check("zero_cmd", command, 0);
      m_err = 1;
      repeat (3) @(posedge CLK);
      #1 check("zero_no_pulse", n_start - c0, 0);
      check_status(0, 0);
      apb_write(16'h04, 32'hE, e);
      m_done = 0; m_err = 0; m_abt = 0;
      check_status(0, 0);

      // Abort in group-1 COMPUTE together with rdy_to_send
      run_job(3, 16, 64, 1, 0, 1, 3);
      // Busy config write, busy read, start while busy, stray b_writedone
      run_job(5, 8, 64, 1, 1, -1, -1);

      // Interrupt enable, job completion, W1C of done
      apb_write(16'h18, 32'h1, e);
      m_irq_en = 1;
      run_job(7, 3, 11, -1, 0, -1, -1);
      check("irq_done", irq, IRQ_BUILD ? 1 : 0);
      apb_write(16'h04, 32'h2, e);
      m_done = 0;
      check("irq_w1c", irq, 0);
      apb_write(16'h18, 32'h0, e);
      m_irq_en = 0;

      // Randomized jobs, some aborted at a random phase
      for (int j = 0; j < 12; j++) begin
         inch  = int'($urandom_range(1, 4095));
         outch = int'($urandom_range(1, 40));
         fl    = int'($urandom_range(1, 65535));
         ngrp  = outch / 8 + ((outch % 8 != 0) ? 1 : 0);
         ag = -1; ap = -1;
         if ($urandom_range(0, 3) == 0) begin
            ag = int'($urandom_range(0, ngrp - 1));
            ap = int'($urandom_range(1, 4));
         end
         run_job(inch, outch, fl, -1, 0, ag, ap);
      end

      // Reset asserted while in SEND of group 1
      start_job(3, 16, 64);
      for (int g = 0; g < 2; g++)
         for (int p = 1; p <= 4; p++)
            if (!(g == 1 && p == 4)) run_phase(p, g, 1);
      check("pre_rst_cmd", command, 4);
      check("pre_rst_grp", grp_idx, 1);
      #2 RESETN = 1'b0;
      #1;
      check("mid_rst_cmd", command, 0);
      check("mid_rst_grp", grp_idx, 0);
      check("mid_rst_start", conv_start, 0);
      check("mid_rst_done", conv_done, 0);
      check("mid_rst_irq", irq, 0);
      check("mid_rst_inch", num_inch, 0);
      check("mid_rst_flen", flen, 0);
      #1 RESETN = 1'b1;
      m_done = 0; m_err = 0; m_abt = 0; m_irq_en = 0;
      @(posedge CLK); #1;
      check_status(0, 0);
      apb_read(16'h14, rd, e);
      check("post_rst_cycles", rd, 0);
      run_job(2, 20, 7, -1, 0, -1, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
